// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC reader, its averaging consumer and the top level.
package adc_pkg;

  // ADC sample width
  localparam int unsigned ADC_W = 10;

  // Default timing, shared by reader-side and top-level blocks
  localparam int unsigned SAMPLE_PERIOD_DEF = 50000;
  localparam int unsigned TIMEOUT_DEF       = 64;
  localparam int unsigned AVG_LOG2_DEF      = 3;

  // Averager FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } adc_state_t;

endpackage : adc_pkg

// File: rtl/adc_tick_gen.sv
// Sample-period counter: counts 0..SAMPLE_PERIOD-1 while enabled, pulses o_tick on the last count.
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick    = i_enable & w_at_last;

  // Free-running period count, parked at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else if (w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule : adc_tick_gen

// File: rtl/adc_sample_averager.sv
// Drives the ADC reader's start pulse on a fixed period, averages 2^AVG_LOG2 results,
// and reports the average with a hysteresis alarm and a sticky reader-timeout error.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int unsigned AVG_LOG2      = AVG_LOG2_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF,
  parameter int unsigned DATA_W        = ADC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              err_clear,
  output logic              adc_start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thresh_hi,
  input  logic [DATA_W-1:0] thresh_lo,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              alarm,
  output logic              timeout_err
);

  localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(1) << AVG_LOG2;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  adc_state_t        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_adc_start;
  logic [DATA_W-1:0] r_avg_out;
  logic              r_avg_valid;
  logic              r_alarm;
  logic              r_err;

  logic              w_tick;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_last;
  logic [DATA_W-1:0] w_avg_new;
  logic              w_alarm_next;

  adc_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_enable(enable),
    .o_tick  (w_tick)
  );

  assign w_acc_sum   = r_acc + ACC_W'(adc_data);
  assign w_cnt_next  = r_cnt + CNT_W'(1);
  assign w_wait_next = r_wait + WAIT_W'(1);
  assign w_last      = (w_cnt_next == CNT_FULL);
  assign w_avg_new   = w_acc_sum[ACC_W-1:AVG_LOG2];

  // Hysteresis decision for the incoming average; set wins over clear
  always_comb begin
    w_alarm_next = r_alarm;
    if (w_avg_new >= thresh_hi) begin
      w_alarm_next = 1'b1;
    end else if (w_avg_new <= thresh_lo) begin
      w_alarm_next = 1'b0;
    end
  end

  // Sampling FSM with registered start, average, alarm and error outputs.
  // The average, strobe and alarm are loaded on the edge that accepts the final
  // sample so they are visible during the single S_OUT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_adc_start <= 1'b0;
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_adc_start <= 1'b0;
      r_avg_valid <= 1'b0;
      if (err_clear) begin
        r_err <= 1'b0;
      end
      if (!enable) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_wait  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_tick) begin
              r_adc_start <= 1'b1;
              r_wait      <= '0;
              r_state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (adc_valid) begin
              r_acc <= w_acc_sum;
              r_cnt <= w_cnt_next;
              if (w_last) begin
                r_avg_out   <= w_avg_new;
                r_avg_valid <= 1'b1;
                r_alarm     <= w_alarm_next;
                r_state     <= S_OUT;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (w_wait_next == WAIT_LIMIT) begin
              r_err   <= 1'b1;
              r_wait  <= w_wait_next;
              r_state <= S_IDLE;
            end else begin
              r_wait <= w_wait_next;
            end
          end
          S_OUT: begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign adc_start   = r_adc_start;
  assign avg_out     = r_avg_out;
  assign avg_valid   = r_avg_valid;
  assign alarm       = r_alarm;
  assign timeout_err = r_err;

endmodule : adc_sample_averager
